mem_target_responder: RTL and testbench

- Target-side responder for translated memory requests.
- Accepts one request at a time: a 32-bit offset plus the region code (1 = RAM, 2 = VGA, 3 = ERR) produced by the CPU-side address translator.
- Forwards the request to the RAM or VGA target port and waits for that port's acknowledge.
- Returns read data, or an error, to the CPU side over a valid/ready response handshake.

---
 rtl/mem_target_responder.sv | 140 ++++++++++++++
 tb/tb_mem_target_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_target_responder.sv
// Target responder: routes one request to RAM/VGA, returns rdata/err; 2-cycle min latency, 1 for ERR.
// Holds response until resp_ready; req_ready only in IDLE. MEM_TARGET_TIMEOUT_EN adds an ack-wait timeout.
module mem_target_responder #(
  parameter int word_width     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [word_width-1:0] req_state,
  input  logic [word_width-1:0] req_addr,
  input  logic                  req_we,
  input  logic [word_width-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [word_width-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  ram_valid,
  output logic [word_width-1:0] ram_addr,
  output logic                  ram_we,
  output logic [word_width-1:0] ram_wdata,
  input  logic                  ram_ack,
  input  logic [word_width-1:0] ram_rdata,
  output logic                  vga_valid,
  output logic [word_width-1:0] vga_addr,
  output logic                  vga_we,
  output logic [word_width-1:0] vga_wdata,
  input  logic                  vga_ack,
  input  logic [word_width-1:0] vga_rdata
);

  typedef enum logic [1:0] {IDLE, RAM_REQ, VGA_REQ, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [word_width-1:0] r_addr;
  logic [word_width-1:0] r_wdata;
  logic [word_width-1:0] r_rdata;
  logic                  r_we;
  logic                  r_err;

  logic w_accept;
  logic w_ram_sel;
  logic w_vga_sel;
  logic w_ram_done;
  logic w_vga_done;
  logic w_timeout;

  assign w_accept   = (r_state == IDLE) && req_valid;
  assign w_ram_sel  = (req_state == word_width'(1));
  assign w_vga_sel  = (req_state == word_width'(2));
  assign w_ram_done = (r_state == RAM_REQ) && ram_ack;
  assign w_vga_done = (r_state == VGA_REQ) && vga_ack;

`ifdef MEM_TARGET_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_waiting;

  assign w_waiting = (r_state == RAM_REQ) || (r_state == VGA_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_tmo_cnt <= '0;
    else if (w_accept)  r_tmo_cnt <= '0;
    else if (w_waiting) r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Count value k marks the (k+1)th waiting cycle; an ack in the last cycle still wins.
  assign w_timeout = w_waiting && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                     && !w_ram_done && !w_vga_done;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_ram_sel)      w_next = RAM_REQ;
          else if (w_vga_sel) w_next = VGA_REQ;
          else                w_next = RESP;
        end
      end
      RAM_REQ: if (ram_ack || w_timeout) w_next = RESP;
      VGA_REQ: if (vga_ack || w_timeout) w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == IDLE);
    resp_valid = (r_state == RESP);
    ram_valid  = (r_state == RAM_REQ);
    vga_valid  = (r_state == VGA_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_we    <= req_we;
      r_rdata <= '0;
      r_err   <= !(w_ram_sel || w_vga_sel);
    end else if (w_ram_done) begin
      r_rdata <= r_we ? '0 : ram_rdata;
      r_err   <= 1'b0;
    end else if (w_vga_done) begin
      r_rdata <= r_we ? '0 : vga_rdata;
      r_err   <= 1'b0;
    end else if (w_timeout) begin
      r_rdata <= '0;
      r_err   <= 1'b1;
    end
  end

  // Both target ports share the captured request; only the strobe selects the target.
  assign ram_addr   = r_addr;
  assign ram_we     = r_we;
  assign ram_wdata  = r_wdata;
  assign vga_addr   = r_addr;
  assign vga_we     = r_we;
  assign vga_wdata  = r_wdata;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_target_responder.sv
// Directed bench for mem_target_responder: RAM/VGA/ERR paths, backpressure, async reset, optional timeout.
module tb_mem_target_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_state;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_valid;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  logic        vga_valid;
  logic [31:0] vga_addr;
  logic        vga_we;
  logic [31:0] vga_wdata;
  logic        vga_ack;
  logic [31:0] vga_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_target_responder #(.word_width(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_valid(ram_valid), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .vga_valid(vga_valid), .vga_addr(vga_addr), .vga_we(vga_we),
    .vga_wdata(vga_wdata), .vga_ack(vga_ack), .vga_rdata(vga_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1ns past it; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] st, input logic [31:0] a,
                          input logic we, input logic [31:0] wd);
    req_valid = 1'b1;
    req_state = st;
    req_addr  = a;
    req_we    = we;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_state = '0; req_addr = '0; req_we = 1'b0;
    req_wdata = '0; resp_ready = 1'b1; ram_ack = 1'b0; ram_rdata = '0;
    vga_ack = 1'b0; vga_rdata = '0;
    tick(); tick();

    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_ram_valid",  {31'b0, ram_valid},  32'd0);
    check_eq("rst_vga_valid",  {31'b0, vga_valid},  32'd0);
    check_eq("rst_req_ready",  {31'b0, req_ready},  32'd1);
    check_eq("rst_ram_addr",   ram_addr,   32'd0);
    check_eq("rst_vga_wdata",  vga_wdata,  32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_resp_err",   {31'b0, resp_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // RAM read, ack in the first target cycle
    send_req(32'd1, 32'h10, 1'b0, 32'h0);
    check_eq("ram_rd_valid",    {31'b0, ram_valid}, 32'd1);
    check_eq("ram_rd_addr",     ram_addr, 32'h10);
    check_eq("ram_rd_we",       {31'b0, ram_we}, 32'd0);
    check_eq("ram_rd_vga_idle", {31'b0, vga_valid}, 32'd0);
    check_eq("ram_rd_busy",     {31'b0, req_ready}, 32'd0);
    ram_ack = 1'b1; ram_rdata = 32'hDEADBEEF;
    tick();
    ram_ack = 1'b0; ram_rdata = '0;
    check_eq("ram_rd_resp_valid", {31'b0, resp_valid}, 32'd1);
    check_eq("ram_rd_rdata",      resp_rdata, 32'hDEADBEEF);
    check_eq("ram_rd_err",        {31'b0, resp_err}, 32'd0);
    check_eq("ram_rd_valid_drop", {31'b0, ram_valid}, 32'd0);
    check_eq("ram_rd_vga_idle2",  {31'b0, vga_valid}, 32'd0);
    tick();
    check_eq("ram_rd_back_idle",  {31'b0, req_ready}, 32'd1);

    // VGA write held for 3 cycles; stray RAM ack must be ignored
    send_req(32'd2, 32'h1F40, 1'b1, 32'h00FF00FF);
    vga_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      check_eq("vga_wr_valid", {31'b0, vga_valid}, 32'd1);
      check_eq("vga_wr_addr",  vga_addr, 32'h1F40);
      check_eq("vga_wr_wdata", vga_wdata, 32'h00FF00FF);
      check_eq("vga_wr_we",    {31'b0, vga_we}, 32'd1);
      check_eq("vga_wr_ram_idle", {31'b0, ram_valid}, 32'd0);
      ram_ack = (i < 2);
      vga_ack = (i == 2);
      tick();
    end
    ram_ack = 1'b0; vga_ack = 1'b0;
    check_eq("vga_wr_resp_valid", {31'b0, resp_valid}, 32'd1);
    check_eq("vga_wr_rdata",      resp_rdata, 32'd0);
    check_eq("vga_wr_err",        {31'b0, resp_err}, 32'd0);
    check_eq("vga_wr_valid_drop", {31'b0, vga_valid}, 32'd0);
    tick();

    // Error regions: 3, 7, and a code whose low bits alone would look like RAM
    begin
      logic [31:0] err_codes [3];
      err_codes[0] = 32'd3; err_codes[1] = 32'h7; err_codes[2] = 32'h101;
      for (int i = 0; i < 3; i++) begin
        send_req(err_codes[i], 32'h44, 1'b0, 32'h0);
        check_eq("err_resp_valid", {31'b0, resp_valid}, 32'd1);
        check_eq("err_flag",       {31'b0, resp_err}, 32'd1);
        check_eq("err_rdata",      resp_rdata, 32'd0);
        check_eq("err_ram_idle",   {31'b0, ram_valid}, 32'd0);
        check_eq("err_vga_idle",   {31'b0, vga_valid}, 32'd0);
        tick();
      end
    end

    // Response backpressure with a pending ERR request waiting behind it
    resp_ready = 1'b0;
    send_req(32'd1, 32'h20, 1'b0, 32'h0);
    ram_ack = 1'b1; ram_rdata = 32'hCAFEF00D;
    req_valid = 1'b1; req_state = 32'd3;
    tick();
    ram_ack = 1'b0; ram_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      check_eq("bp_rdata",      resp_rdata, 32'hCAFEF00D);
      check_eq("bp_req_ready",  {31'b0, req_ready}, 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    check_eq("bp_still_valid", {31'b0, resp_valid}, 32'd1);
    tick();
    check_eq("bp_resume_ready", {31'b0, req_ready}, 32'd1);
    check_eq("bp_resume_nresp", {31'b0, resp_valid}, 32'd0);
    tick();
    req_valid = 1'b0;
    check_eq("bp_next_resp", {31'b0, resp_valid}, 32'd1);
    check_eq("bp_next_err",  {31'b0, resp_err}, 32'd1);
    tick();

    // Async reset while waiting for a RAM ack
    send_req(32'd1, 32'h30, 1'b0, 32'h0);
    check_eq("rstmid_valid_pre", {31'b0, ram_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("rstmid_async_drop", {31'b0, ram_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    ram_ack = 1'b1; ram_rdata = 32'h99999999;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rstmid_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    ram_ack = 1'b0;
    send_req(32'd1, 32'h34, 1'b0, 32'h0);
    check_eq("rstmid_next_addr", ram_addr, 32'h34);
    ram_ack = 1'b1; ram_rdata = 32'h0BADCAFE;
    tick();
    ram_ack = 1'b0;
    check_eq("rstmid_next_resp",  {31'b0, resp_valid}, 32'd1);
    check_eq("rstmid_next_rdata", resp_rdata, 32'h0BADCAFE);
    tick();

`ifdef MEM_TARGET_TIMEOUT_EN
    send_req(32'd1, 32'h50, 1'b0, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      check_eq("tmo_waiting", {31'b0, resp_valid}, 32'd0);
      tick();
    end
    check_eq("tmo_resp_valid", {31'b0, resp_valid}, 32'd1);
    check_eq("tmo_err",        {31'b0, resp_err}, 32'd1);
    check_eq("tmo_rdata",      resp_rdata, 32'd0);
    check_eq("tmo_ram_drop",   {31'b0, ram_valid}, 32'd0);
    tick();
    send_req(32'd1, 32'h54, 1'b0, 32'h0);
    for (int i = 1; i <= 15; i++) tick();
    check_eq("tmo_last_wait", {31'b0, ram_valid}, 32'd1);
    ram_ack = 1'b1; ram_rdata = 32'h000055AA;
    tick();
    ram_ack = 1'b0;
    check_eq("tmo_ack_wins_valid", {31'b0, resp_valid}, 32'd1);
    check_eq("tmo_ack_wins_err",   {31'b0, resp_err}, 32'd0);
    check_eq("tmo_ack_wins_rdata", resp_rdata, 32'h000055AA);
    tick();
`else
    // Without the timeout the FSM keeps waiting well past 16 cycles
    send_req(32'd1, 32'h50, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) tick();
    check_eq("notmo_still_wait", {31'b0, ram_valid}, 32'd1);
    check_eq("notmo_no_resp",    {31'b0, resp_valid}, 32'd0);
    ram_ack = 1'b1; ram_rdata = 32'h000055AA;
    tick();
    ram_ack = 1'b0;
    check_eq("notmo_resp_rdata", resp_rdata, 32'h000055AA);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
